// File: rtl/sr_latch_reg.sv
// Bank of WIDTH clock-synchronous SR cells with complementary outputs and sticky S=R=1 flags.
// Latency: one clk from sampled s/r to q/qn/illegal; any_ill is a combinational OR of flops.
// Backpressure: none; s/r are sampled every rising edge and always accepted.
module sr_latch_reg #(
  parameter int   WIDTH    = 1,
  parameter int   PRIORITY = 0,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] illegal,
  output logic             any_ill
);

  // Resolution mode for a cell that sees s=r=1 on the same edge.
  typedef enum logic [1:0] {
    PRIO_HOLD = 2'd0,
    PRIO_SET  = 2'd1,
    PRIO_CLR  = 2'd2
  } prio_e;

  // Out-of-range PRIORITY values fall back to hold so a bad override
  // degrades to the safest behaviour instead of an undefined one.
  localparam prio_e PRIO_MODE = (PRIORITY == 1) ? PRIO_SET :
                                (PRIORITY == 2) ? PRIO_CLR : PRIO_HOLD;

  localparam logic [WIDTH-1:0] Q_RST = {WIDTH{RST_VAL}};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] illegal_q;
  logic [WIDTH-1:0] illegal_d;
  logic [WIDTH-1:0] conflict;

  // Per-cell next state: legal requests set/clear, conflicts resolved by mode.
  always_comb begin
    q_d       = q_q;
    illegal_d = illegal_q;
    conflict  = s & r;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          unique case (PRIO_MODE)
            PRIO_SET: q_d[i] = 1'b1;
            PRIO_CLR: q_d[i] = 1'b0;
            default:  q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
    // Sticky: a conflict only ever sets the flag; only reset clears it.
    illegal_d = illegal_q | conflict;
  end

  // State registers; synchronous reset overrides any s/r in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= Q_RST;
      illegal_q <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs come straight from flops, so qn is always the exact complement
  // of q and there is no combinational path from s/r.
  assign q       = q_q;
  assign qn      = ~q_q;
  assign illegal = illegal_q;
  assign any_ill = |illegal_q;

endmodule

// File: tb/tb_sr_latch_reg.sv
// Directed bench for sr_latch_reg across all three conflict modes, WIDTH=4 and RST_VAL=1.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: not applicable.
module tb_sr_latch_reg;

  logic       clk;
  logic       rst;
  logic       s1, r1;
  logic [3:0] s4, r4;

  logic q_p0, qn_p0, ill_p0, any_p0;
  logic q_p1, qn_p1, ill_p1, any_p1;
  logic q_p2, qn_p2, ill_p2, any_p2;
  logic [3:0] q_w4, qn_w4, ill_w4;
  logic       any_w4;
  logic [3:0] q_rv, qn_rv, ill_rv;
  logic       any_rv;

  int total = 0;
  int bad   = 0;

  sr_latch_reg #(.WIDTH(1), .PRIORITY(0), .RST_VAL(1'b0)) u_p0 (
    .clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_p0), .qn(qn_p0), .illegal(ill_p0), .any_ill(any_p0));
  sr_latch_reg #(.WIDTH(1), .PRIORITY(1), .RST_VAL(1'b0)) u_p1 (
    .clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_p1), .qn(qn_p1), .illegal(ill_p1), .any_ill(any_p1));
  sr_latch_reg #(.WIDTH(1), .PRIORITY(2), .RST_VAL(1'b0)) u_p2 (
    .clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_p2), .qn(qn_p2), .illegal(ill_p2), .any_ill(any_p2));
  sr_latch_reg #(.WIDTH(4), .PRIORITY(2), .RST_VAL(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4),
    .q(q_w4), .qn(qn_w4), .illegal(ill_w4), .any_ill(any_w4));
  sr_latch_reg #(.WIDTH(4), .PRIORITY(1), .RST_VAL(1'b1)) u_rv (
    .clk(clk), .rst(rst), .s(s4), .r(r4),
    .q(q_rv), .qn(qn_rv), .illegal(ill_rv), .any_ill(any_rv));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compact check of one WIDTH=1 instance: q, qn, illegal, any_ill.
  task automatic chk1(input string tag, input logic q, input logic qn, input logic il,
                      input logic an, input logic eq, input logic eil);
    chk({tag, ".q"},   {3'b0, q},  {3'b0, eq});
    chk({tag, ".qn"},  {3'b0, qn}, {3'b0, ~eq});
    chk({tag, ".ill"}, {3'b0, il}, {3'b0, eil});
    chk({tag, ".any"}, {3'b0, an}, {3'b0, eil});
  endtask

  task automatic chk_all1(input string tag, input logic e0, input logic e1,
                          input logic e2, input logic eil);
    chk1({tag, ".p0"}, q_p0, qn_p0, ill_p0, any_p0, e0, eil);
    chk1({tag, ".p1"}, q_p1, qn_p1, ill_p1, any_p1, e1, eil);
    chk1({tag, ".p2"}, q_p2, qn_p2, ill_p2, any_p2, e2, eil);
  endtask

  initial begin
    rst = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    tick();
    chk_all1("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.w4.q",   q_w4,   4'b0000);
    chk("reset.w4.qn",  qn_w4,  4'b1111);
    chk("reset.w4.ill", ill_w4, 4'b0000);
    chk("reset.rv.q",   q_rv,   4'b1111);
    chk("reset.rv.qn",  qn_rv,  4'b0000);

    rst = 1'b0;
    tick();
    tick();
    chk_all1("idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    s1 = 1'b1; r1 = 1'b0;
    // Before the edge the new request must not show through.
    #2;
    chk("nocomb.p0.q", {3'b0, q_p0}, 4'b0000);
    tick();
    chk_all1("set", 1'b1, 1'b1, 1'b1, 1'b0);

    s1 = 1'b0; r1 = 1'b0;
    tick();
    chk_all1("hold1", 1'b1, 1'b1, 1'b1, 1'b0);

    s1 = 1'b0; r1 = 1'b1;
    tick();
    chk_all1("clr", 1'b0, 1'b0, 1'b0, 1'b0);

    s1 = 1'b1; r1 = 1'b0;
    tick();
    chk_all1("set2", 1'b1, 1'b1, 1'b1, 1'b0);

    // Conflict from q=1: hold keeps 1, set keeps 1, clear goes to 0.
    s1 = 1'b1; r1 = 1'b1;
    tick();
    chk_all1("conf_q1", 1'b1, 1'b1, 1'b0, 1'b1);

    s1 = 1'b0; r1 = 1'b1;
    tick();
    chk_all1("clr_sticky", 1'b0, 1'b0, 1'b0, 1'b1);

    s1 = 1'b1; r1 = 1'b0;
    tick();
    chk_all1("set_sticky", 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset wins over a simultaneous set request.
    rst = 1'b1; s1 = 1'b1; r1 = 1'b0;
    tick();
    chk_all1("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.rv.q", q_rv, 4'b1111);

    // Conflict from q=0: hold keeps 0, set goes to 1, clear keeps 0.
    rst = 1'b0; s1 = 1'b1; r1 = 1'b1;
    tick();
    chk_all1("conf_q0", 1'b0, 1'b1, 1'b0, 1'b1);

    s1 = 1'b0; r1 = 1'b0;
    s4 = 4'b0101; r4 = 4'b1010;
    tick();
    chk("w4.mixed.q",   q_w4,   4'b0101);
    chk("w4.mixed.qn",  qn_w4,  4'b1010);
    chk("w4.mixed.ill", ill_w4, 4'b0000);
    chk("w4.mixed.any", {3'b0, any_w4}, 4'b0000);
    chk("rv.mixed.q",   q_rv,   4'b0101);

    s4 = 4'b1000; r4 = 4'b1000;
    tick();
    chk("w4.conf.q",   q_w4,   4'b0101);
    chk("w4.conf.qn",  qn_w4,  4'b1010);
    chk("w4.conf.ill", ill_w4, 4'b1000);
    chk("w4.conf.any", {3'b0, any_w4}, 4'b0001);
    chk("rv.conf.q",   q_rv,   4'b1101);
    chk("rv.conf.qn",  qn_rv,  4'b0010);
    chk("rv.conf.ill", ill_rv, 4'b1000);

    s4 = 4'b0010; r4 = 4'b0001;
    tick();
    chk("w4.after.q",   q_w4,   4'b0110);
    chk("w4.after.ill", ill_w4, 4'b1000);
    chk("rv.after.q",   q_rv,   4'b1110);
    chk("rv.after.any", {3'b0, any_rv}, 4'b0001);

    s4 = 4'b0000; r4 = 4'b0000;
    tick();
    chk("w4.hold.q", q_w4, 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
